clk_div_dpll: RTL and testbench
===============================

// Module: clk_div_dpll
// PURPOSE
//  Runtime-programmable clock divider, successor to the fixed /2N divider in the DPSK DPLL path.
//  Generates a 50% square clock plus edge strobes from clk100m; the divisor can be reloaded glitch-free.
//  Optional +/-1-cycle phase nudges let the DPLL phase detector steer the recovered bit clock.
// PARAMETERS
//  CNT_W       16  width of half-period counter and divisor
//  DIV_DEFAULT 6   half-period length in clk100m cycles after reset (full period = 2*DIV_DEFAULT)
// PORTS
//  clk100m   in   1      system clock
//  clr       in   1      reset, asynchronous, active-low
//  en        in   1      count enable; low = freeze
//  div_half  in   CNT_W  new half-period length, sampled on div_load
//  div_load  in   1      1-cycle request to load div_half
//  adv       in   1      1-cycle request: shorten current half-period by 1
//  ret       in   1      1-cycle request: lengthen current half-period by 1
//  clk_out   out  1      divided clock (register output)
//  rise_stb  out  1      high for the first clk100m cycle in which clk_out is 1
//  fall_stb  out  1      high for the first clk100m cycle in which clk_out is 0
//  div_ack   out  1      1-cycle pulse when the pending divisor takes effect
// BEHAVIOUR
//  Reset (clr=0, async): cnt=0, clk_out=0, rise_stb=fall_stb=div_ack=0, half_reg=DIV_DEFAULT,
//    pend_valid=0, adj=0. All outputs are defined from reset; there are no X states.
//  Terminal: term = half_reg-1+adj (adj in {-1,0,+1}). When en=1 and cnt>=term: cnt<=0, clk_out<=~clk_out,
//    rise_stb/fall_stb<=1 according to the new clk_out level, adj<=0. Otherwise cnt<=cnt+1 and strobes<=0.
//    The >= compare covers an adv arriving when cnt already equals half_reg-2.
//  Strobes are registered together with clk_out and are coincident with the new level. Latency of
//    1 cycle from the terminal count.
//  en=0: cnt, clk_out and adj hold; strobes and div_ack are 0. div_load, adv and ret are still captured.
//  Divisor load: div_load=1 sets pend<=div_half (0 is clamped to 1) and pend_valid<=1; if already
//    pending, the newest value wins. Applied only at a terminal event: half_reg<=pend, pend_valid<=0,
//    div_ack=1 in the same cycle as the clk_out toggle. The half-period in progress finishes at the old length.
//  div_load in the same cycle as the terminal event: the new value is applied at the following terminal, not this one.
//  Counter arithmetic is CNT_W unsigned; term is computed CNT_W+1 wide so there is no wrap at half_reg=2^CNT_W-1 with ret.
// CONFIGURATION
//  CLK_DIV_DPLL_PHASE_ADJ_EN defined:
//   - adv sets adj=-1, ret sets adj=+1; these apply to the half-period in progress.
//   - adj saturates: a repeat in the same direction is ignored; the opposite direction returns adj to 0.
//   - adv and ret in the same cycle: no change.
//   - adv is ignored when half_reg==1 (no zero-length half-period).
//   - adj is cleared at each terminal event, so at most one nudge per half-period.
//  CLK_DIV_DPLL_PHASE_ADJ_EN undefined:
//   - adv and ret ports remain but are ignored; adj is constant 0 and the adjust logic is not synthesised.
// TESTING
//  T1 reset/default: release clr, en=1 -> clk_out rises at cycle 6; period 12; each strobe 1 cycle wide,
//     aligned with its edge.
//  T2 reload: div_load with div_half=3 at cycle 2 -> first half-period stays 6, next halves are 3 cycles,
//     div_ack at cycle 6. div_half=0 -> half-periods of 1 (clk_out toggles every cycle).
//  T3 enable: en=0 for 4 cycles mid-half -> that half-period stretches by exactly 4; no strobes while en=0.
//  T4 phase (macro on): adv at cnt=1 -> half-period is 5; ret -> 7; adv+ret same cycle -> 6;
//     two adv in one half -> 5; adv at half_reg=1 -> no effect. Macro off: all of these give 6.
//  T5 reset mid-op: clr low while clk_out=1 and a load is pending -> clk_out=0 immediately;
//     after release, period is 12 and no div_ack.
//  T6 wide: CNT_W=4, div_half=15 with ret -> 16-cycle half-period, no wrap.

Source files
------------

// File: rtl/clk_div_dpll.sv
// Runtime-programmable 50% clock divider with edge strobes, glitch-free divisor reload and
// optional +/-1-cycle phase nudges (enabled by defining CLK_DIV_DPLL_PHASE_ADJ_EN).
module clk_div_dpll #(
  parameter int          CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 6
) (
  input  logic             clk100m,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] div_half,
  input  logic             div_load,
  input  logic             adv,
  input  logic             ret,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             div_ack
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE_N   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ack_q, ack_d;
  logic [CNT_W:0]   adj_ext;
  logic [CNT_W:0]   term;
  logic             term_hit;
  logic [CNT_W-1:0] load_val;

  // One bit wider than the counter so half_reg = 2^CNT_W-1 plus a retard cannot wrap.
  assign term     = {1'b0, half_q} - ONE_W + adj_ext;
  assign term_hit = en && ({1'b0, cnt_q} >= term);
  assign load_val = (div_half == '0) ? ONE_N : div_half;

`ifdef CLK_DIV_DPLL_PHASE_ADJ_EN
  // adj encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1 (two's complement).
  logic [1:0] adj_q, adj_d;

  always_comb begin
    adj_d = adj_q;
    if (term_hit)
      adj_d = 2'b00;
    else if (adv && !ret && (half_q != ONE_N))
      adj_d = (adj_q == 2'b01) ? 2'b00 : 2'b11;
    else if (ret && !adv)
      adj_d = (adj_q == 2'b11) ? 2'b00 : 2'b01;
  end

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) adj_q <= 2'b00;
    else      adj_q <= adj_d;
  end

  assign adj_ext = {{(CNT_W-1){adj_q[1]}}, adj_q};
`else
  logic unused_phase;
  assign unused_phase = adv ^ ret;
  assign adj_ext      = '0;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    ack_d      = 1'b0;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (term_hit) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      rise_d = ~clk_q;
      fall_d = clk_q;
      if (pend_vld_q) begin
        half_d     = pend_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (en) begin
      cnt_d = cnt_q + ONE_N;
    end
    // A load coinciding with a terminal stays pending for the next one.
    if (div_load) begin
      pend_d     = load_val;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk100m or negedge clr) begin
    if (!clr) begin
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
      half_q     <= DIV_RST;
      pend_q     <= DIV_RST;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign clk_out  = clk_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign div_ack  = ack_q;

endmodule

// File: tb/tb_clk_div_dpll.sv
// Directed bench for clk_div_dpll: default period, reload, enable freeze, phase nudges,
// mid-operation reset and a narrow (CNT_W=4) instance at the top of its range.
module tb_clk_div_dpll;

`ifdef CLK_DIV_DPLL_PHASE_ADJ_EN
  localparam int ADJ = 1;
`else
  localparam int ADJ = 0;
`endif

  logic        clk100m = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0, div_load = 1'b0, adv = 1'b0, ret = 1'b0;
  logic [15:0] div_half = '0;
  logic        clk_out, rise_stb, fall_stb, div_ack;

  logic        w_en = 1'b0, w_load = 1'b0, w_adv = 1'b0, w_ret = 1'b0;
  logic [3:0]  w_half = '0;
  logic        w_clk, w_rise, w_fall, w_ack;

  clk_div_dpll #(.CNT_W(16), .DIV_DEFAULT(6)) u_dut (
    .clk100m(clk100m), .clr(clr), .en(en), .div_half(div_half), .div_load(div_load),
    .adv(adv), .ret(ret), .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
    .div_ack(div_ack)
  );

  clk_div_dpll #(.CNT_W(4), .DIV_DEFAULT(6)) u_wide (
    .clk100m(clk100m), .clr(clr), .en(w_en), .div_half(w_half), .div_load(w_load),
    .adv(w_adv), .ret(w_ret), .clk_out(w_clk), .rise_stb(w_rise), .fall_stb(w_fall),
    .div_ack(w_ack)
  );

  always #5 clk100m = ~clk100m;

  int cyc = 0;
  always @(posedge clk100m) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next strobe; t is the posedge count it follows, -1 on timeout.
  task automatic next_edge(input bit wide, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk100m);
      if (wide ? (w_rise | w_fall) : (rise_stb | fall_stb)) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    div_half = v;
    div_load = 1'b1;
    @(posedge clk100m);
    #1 div_load = 1'b0;
  endtask

  task automatic pulse_ar(input logic a, input logic r);
    adv = a;
    ret = r;
    @(posedge clk100m);
    #1;
    adv = 1'b0;
    ret = 1'b0;
  endtask

  // Nudges at cnt=1 and cnt=2 of a fresh half-period of 6, then measures its length.
  task automatic seg(input string tag, input logic a1, input logic r1,
                     input logic a2, input logic r2, input int exp);
    int e0, tt;
    e0 = cyc;
    @(negedge clk100m);
    pulse_ar(a1, r1);
    @(negedge clk100m);
    pulse_ar(a2, r2);
    next_edge(1'b0, tt);
    check(tag, tt - e0, exp);
  endtask

  initial begin
    int t, e, base;

    // T1: reset state and default period
    repeat (3) @(negedge clk100m);
    check("rst_out", {clk_out, rise_stb, fall_stb, div_ack}, 4'b0000);
    check("rst_wide", {w_clk, w_rise, w_fall, w_ack}, 4'b0000);
    clr = 1'b1;
    en  = 1'b1;
    base = cyc;
    next_edge(1'b0, t);
    check("t1_rise_at", t - base, 6);
    check("t1_rise_lvl", {clk_out, rise_stb, fall_stb}, 3'b110);
    @(negedge clk100m);
    check("t1_stb_width", {clk_out, rise_stb, fall_stb}, 3'b100);
    next_edge(1'b0, t);
    check("t1_fall_at", t - base, 12);
    check("t1_fall_lvl", {clk_out, rise_stb, fall_stb}, 3'b001);
    next_edge(1'b0, t);
    check("t1_period", t - base, 18);

    // T2: reload 3 mid-half, then 0 (clamped to 1), then 6 on a terminal cycle
    e = t;
    repeat (2) @(negedge clk100m);
    pulse_load(16'd3);
    next_edge(1'b0, t);
    check("t2_old_half", t - e, 6);
    check("t2_ack", div_ack, 1'b1);
    next_edge(1'b0, t);
    check("t2_new_half", t - e, 9);
    check("t2_ack_once", div_ack, 1'b0);
    next_edge(1'b0, t);
    e = t;
    pulse_load(16'd0);
    next_edge(1'b0, t);
    check("t2_zero_ack_at", t - e, 3);
    check("t2_zero_ack", div_ack, 1'b1);
    next_edge(1'b0, t);
    check("t2_half1_a", t - e, 4);
    next_edge(1'b0, t);
    check("t2_half1_b", t - e, 5);
    pulse_load(16'd6);
    next_edge(1'b0, t);
    check("t2_load_at_term", t - e, 6);
    check("t2_no_ack_same", div_ack, 1'b0);
    next_edge(1'b0, t);
    check("t2_ack_next_at", t - e, 7);
    check("t2_ack_next", div_ack, 1'b1);
    next_edge(1'b0, t);
    check("t2_back_to_6", t - e, 13);

    // T3: freeze 4 cycles mid-half; a load issued while frozen is still captured
    e = t;
    repeat (2) @(negedge clk100m);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk100m);
      check("t3_no_stb", {rise_stb, fall_stb, div_ack}, 3'b000);
      if (i == 1) pulse_load(16'd4);
    end
    en = 1'b1;
    next_edge(1'b0, t);
    check("t3_stretch", t - e, 10);
    check("t3_frozen_load_ack", div_ack, 1'b1);
    next_edge(1'b0, t);
    check("t3_half4", t - e, 14);

    // T4: phase nudges on half-periods of 6
    e = t;
    pulse_load(16'd6);
    next_edge(1'b0, t);
    check("t4_setup", t - e, 4);
    seg("t4_adv",     1'b1, 1'b0, 1'b0, 1'b0, 6 - ADJ);
    seg("t4_ret",     1'b0, 1'b1, 1'b0, 1'b0, 6 + ADJ);
    seg("t4_both",    1'b1, 1'b1, 1'b0, 1'b0, 6);
    seg("t4_adv_x2",  1'b1, 1'b0, 1'b1, 1'b0, 6 - ADJ);
    seg("t4_ret_x2",  1'b0, 1'b1, 1'b0, 1'b1, 6 + ADJ);
    seg("t4_adv_ret", 1'b1, 1'b0, 1'b0, 1'b1, 6);
    seg("t4_plain",   1'b0, 1'b0, 1'b0, 1'b0, 6);
    // adv captured while frozen at half_reg=1 must not create a zero-length half
    e = cyc;
    pulse_load(16'd1);
    next_edge(1'b0, t);
    check("t4_h1_setup", t - e, 6);
    e = t;
    en = 1'b0;
    pulse_ar(1'b1, 1'b0);
    @(negedge clk100m);
    en = 1'b1;
    next_edge(1'b0, t);
    check("t4_adv_half1", t - e, 2);
    next_edge(1'b0, t);
    check("t4_adv_half1_next", t - e, 3);
    pulse_load(16'd6);
    next_edge(1'b0, t);
    next_edge(1'b0, t);
    check("t4_restore_ack", div_ack, 1'b1);

    // T5: reset while clk_out=1 with a load pending
    if (clk_out == 1'b0) next_edge(1'b0, t);
    check("t5_pre_high", clk_out, 1'b1);
    pulse_load(16'd3);
    @(negedge clk100m);
    clr = 1'b0;
    #1;
    check("t5_async_clr", {clk_out, rise_stb, fall_stb, div_ack}, 4'b0000);
    repeat (2) @(negedge clk100m);
    clr = 1'b1;
    base = cyc;
    next_edge(1'b0, t);
    check("t5_rise_at", t - base, 6);
    check("t5_no_ack_r", div_ack, 1'b0);
    next_edge(1'b0, t);
    check("t5_fall_at", t - base, 12);
    next_edge(1'b0, t);
    check("t5_period", t - base, 18);
    check("t5_no_ack", div_ack, 1'b0);

    // T6: CNT_W=4 at div_half=15, retarded half-period must not wrap
    w_en   = 1'b1;
    w_half = 4'd15;
    w_load = 1'b1;
    base   = cyc;
    @(posedge clk100m);
    #1 w_load = 1'b0;
    next_edge(1'b1, t);
    check("t6_first", t - base, 6);
    check("t6_ack", w_ack, 1'b1);
    e = t;
    @(negedge clk100m);
    w_ret = 1'b1;
    @(posedge clk100m);
    #1 w_ret = 1'b0;
    next_edge(1'b1, t);
    check("t6_ret_half", t - e, 15 + ADJ);
    check("t6_level", w_clk, 1'b0);
    e = t;
    next_edge(1'b1, t);
    check("t6_plain_half", t - e, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
